// File: rtl/alu_if.sv
// Execute-stage ALU bus: the instruction word and two register operands in,
// the registered result and {zero, negative, overflow} flags out.
interface alu_if;
  logic [31:0] instruction;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (output instruction, regA, regB, input result, flags);
  modport slave  (input instruction, regA, regB, output result, flags);
endinterface

// File: rtl/alu.sv
// Registered 32-bit MIPS-style integer ALU: decodes one instruction per clock.
// Shift instructions exist only when ALU_SHIFT_EN is defined.
module alu (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] sum_rr;
  logic [31:0] sum_ri;
  logic [31:0] diff_rr;
  logic [31:0] result_next;
  logic        ovf_next;
  logic        supported;
  logic [31:0] result_reg;
  logic [2:0]  flags_reg;
  logic        unused_bits;

  assign op       = bus.instruction[31:26];
  assign shamt    = bus.instruction[10:6];
  assign funct    = bus.instruction[5:0];
  assign imm      = bus.instruction[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  // Only the low bit of each register-number field picks an operand.
  assign src1 = bus.instruction[21] ? bus.regB : bus.regA;
  assign src2 = bus.instruction[16] ? bus.regB : bus.regA;

  assign sum_rr  = src1 + src2;
  assign sum_ri  = src1 + imm_sext;
  assign diff_rr = src1 - src2;

  assign unused_bits = ^{bus.instruction[25:22], bus.instruction[20:17], shamt};

  always_comb begin
    result_next = '0;
    ovf_next    = 1'b0;
    supported   = 1'b1;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: begin
            result_next = sum_rr;
            ovf_next    = (src1[31] == src2[31]) && (sum_rr[31] != src1[31]);
          end
          6'b100001: result_next = sum_rr;
          6'b100010: begin
            result_next = diff_rr;
            ovf_next    = (src1[31] != src2[31]) && (diff_rr[31] != src1[31]);
          end
          6'b100011: result_next = diff_rr;
          6'b100100: result_next = src1 & src2;
          6'b100101: result_next = src1 | src2;
          6'b100110: result_next = src1 ^ src2;
          6'b100111: result_next = ~(src1 | src2);
          6'b101010: result_next = {31'd0, $signed(src1) < $signed(src2)};
          6'b101011: result_next = {31'd0, src1 < src2};
`ifdef ALU_SHIFT_EN
          6'b000000: result_next = src2 << shamt;
          6'b000010: result_next = src2 >> shamt;
          6'b000011: result_next = $unsigned($signed(src2) >>> shamt);
          6'b000100: result_next = src2 << src1[4:0];
          6'b000110: result_next = src2 >> src1[4:0];
          6'b000111: result_next = $unsigned($signed(src2) >>> src1[4:0]);
`endif
          default:   supported = 1'b0;
        endcase
      end
      6'b001000: begin
        result_next = sum_ri;
        ovf_next    = (src1[31] == imm_sext[31]) && (sum_ri[31] != src1[31]);
      end
      6'b001001: result_next = sum_ri;
      6'b001010: result_next = {31'd0, $signed(src1) < $signed(imm_sext)};
      6'b001011: result_next = {31'd0, src1 < imm_sext};
      6'b001100: result_next = src1 & imm_zext;
      6'b001101: result_next = src1 | imm_zext;
      6'b001110: result_next = src1 ^ imm_zext;
      default:   supported = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      // Unsupported encodings leave result 0, so only zero needs gating.
      result_reg <= result_next;
      flags_reg  <= {supported && (result_next == 32'd0), result_next[31], ovf_next};
    end
  end

  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;
endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors checked with immediate assertions.
module tb_alu;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_if bus ();

  alu dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic rs, input logic rt,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'b000000, 4'b0000, rs, 4'b0000, rt, 5'b00000, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic rs,
                                        input logic [15:0] im);
    return {opc, 4'b0000, rs, 5'b00000, im};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] instr,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic [2:0] exp_flags);
    @(negedge clk);
    bus.instruction = instr;
    bus.regA        = a;
    bus.regB        = b;
    @(posedge clk);
    #1;
    check({tag, ".result"}, bus.result, exp_res);
    check({tag, ".flags"}, {29'd0, bus.flags}, {29'd0, exp_flags});
    $display("op %-8s instr=%h a=%h b=%h -> result=%h flags=%b",
             tag, instr, a, b, bus.result, bus.flags);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b1;
    bus.instruction = '0;
    bus.regA        = '0;
    bus.regB        = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset.result", bus.result, 32'd0);
    check("reset.flags", {29'd0, bus.flags}, 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold.result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("add",      rtype(0, 1, 0, 6'b100000), 32'd4, 32'd5, 32'd9, 3'b000);
    step("add_neg",  rtype(0, 0, 0, 6'b100000), -32'sd4, 32'd0, 32'hFFFFFFF8, 3'b010);
    step("add_ovf",  rtype(0, 1, 0, 6'b100000), 32'h7FFFFFF8, 32'h7FFFFFF9, 32'hFFFFFFF1, 3'b011);
    step("add_zero", rtype(0, 1, 0, 6'b100000), -32'sd10, 32'd10, 32'd0, 3'b100);
    step("addu_wrap", rtype(0, 1, 0, 6'b100001), 32'h7FFFFFF8, 32'h7FFFFFF9, 32'hFFFFFFF1, 3'b010);
    step("addi_neg", itype(6'b001000, 1, 16'hFF9C), 32'd0, 32'd19, 32'hFFFFFFAF, 3'b010);
    step("addi_ovf", itype(6'b001000, 0, 16'd100), 32'h7FFFFFF8, 32'd0, 32'h8000005C, 3'b011);
    step("addiu",    itype(6'b001001, 0, 16'd100), 32'h7FFFFFF8, 32'd0, 32'h8000005C, 3'b010);
    step("sub",      rtype(1, 0, 0, 6'b100010), -32'sd65, -32'sd39, 32'd26, 3'b000);
    step("sub_ovf",  rtype(0, 1, 0, 6'b100010), 32'h80000008, 32'h7FFFFFF9, 32'h0000000F, 3'b001);
    step("subu",     rtype(0, 1, 0, 6'b100011), 32'd50, 32'd120, 32'hFFFFFFBA, 3'b010);
    step("and",      rtype(0, 1, 0, 6'b100100), 32'hFFF0FFFF, 32'hABCD1234, 32'hABC01234, 3'b010);
    step("or",       rtype(0, 1, 0, 6'b100101), 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 3'b000);
    step("nor",      rtype(0, 1, 0, 6'b100111), 32'hFFF0FFFF, 32'hABCD1234, 32'h00020000, 3'b000);
    step("xori",     itype(6'b001110, 1, 16'hFFFF), 32'd0, 32'hFFFFFFFF, 32'hFFFF0000, 3'b010);
    step("xor_eq",   rtype(0, 0, 0, 6'b100110), 32'h12345678, 32'd0, 32'd0, 3'b100);
    step("slt",      rtype(0, 1, 0, 6'b101010), 32'hFFFFFFFF, 32'd1, 32'd1, 3'b000);
    step("sltu",     rtype(0, 1, 0, 6'b101011), 32'hFFFFFFFF, 32'd1, 32'd0, 3'b100);
    step("slti",     itype(6'b001010, 0, 16'hFFFF), 32'd5, 32'd0, 32'd0, 3'b100);
    step("sltiu",    itype(6'b001011, 0, 16'hFFFF), 32'd5, 32'd0, 32'd1, 3'b000);
    step("andi",     itype(6'b001100, 0, 16'h8001), 32'hFFFFFFFF, 32'd0, 32'h00008001, 3'b000);
    step("ori",      itype(6'b001101, 0, 16'h1234), 32'h80000000, 32'd0, 32'h80001234, 3'b010);
    step("bad_op",   itype(6'b111111, 0, 16'h0000), 32'd0, 32'd0, 32'd0, 3'b000);
    step("bad_fn",   rtype(0, 0, 0, 6'b001000), 32'd0, 32'd0, 32'd0, 3'b000);
`ifdef ALU_SHIFT_EN
    step("sra",      rtype(0, 1, 5'd4, 6'b000011), 32'd0, 32'h80000000, 32'hF8000000, 3'b010);
    step("sllv",     rtype(0, 1, 0, 6'b000100), 32'd8, 32'd1, 32'h00000100, 3'b000);
`else
    step("sra",      rtype(0, 1, 5'd4, 6'b000011), 32'd0, 32'h80000000, 32'd0, 3'b000);
    step("sllv",     rtype(0, 1, 0, 6'b000100), 32'd8, 32'd1, 32'd0, 3'b000);
`endif

    // Mid-stream reset: output clears without a clock edge and in-flight op is lost.
    step("pre_rst",  rtype(0, 1, 0, 6'b100000), 32'd4, 32'd5, 32'd9, 3'b000);
    bus.instruction = rtype(0, 1, 0, 6'b100000);
    bus.regA        = 32'h7FFFFFF8;
    bus.regB        = 32'h7FFFFFF9;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.result", bus.result, 32'd0);
    check("async_rst.flags", {29'd0, bus.flags}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.result", bus.result, 32'd0);
    check("rst_hold.flags", {29'd0, bus.flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", rtype(0, 1, 0, 6'b100000), 32'd4, 32'd5, 32'd9, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
